// File: rtl/spike_pkg.sv
// Shared types and default widths for the spike-rate decoder.
// No logic; constants and the FSM state encoding only.
package spike_pkg;
    localparam int COUNT_W_DEF  = 8;
    localparam int WINDOW_W_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;
endpackage

// File: rtl/spike_window_timer.sv
// Window down-counter: flags the final cycle of each counting window.
// Latency: last is combinational from the remaining-cycles register.
// Backpressure: none; the window runs whenever run is high.
module spike_window_timer
    import spike_pkg::*;
#(
    parameter int WINDOW_W = WINDOW_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                run,
    input  logic [WINDOW_W-1:0] window_len,
    output logic                last,
    output logic                restart
);
    logic [WINDOW_W-1:0] remaining;
    logic [WINDOW_W-1:0] load_val;

    // A zero length would never expire, so it behaves as a one-cycle window.
    assign load_val = (window_len == '0) ? WINDOW_W'(1) : window_len;
    assign last     = run && (remaining == WINDOW_W'(1));
    assign restart  = start || last;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            remaining <= '0;
        end else if (restart) begin
            remaining <= load_val;
        end else if (run) begin
            remaining <= remaining - WINDOW_W'(1);
        end else begin
            remaining <= '0;
        end
    end
endmodule

// File: rtl/spike_decoder.sv
// Spike-rate decoder: counts spikes per window, publishes the count via valid/ready.
// Latency: result valid 1 cycle after a window's last cycle; windows run back to back.
// Backpressure: none upstream; an unconsumed result is overwritten and overrun pulses.
// Option: define SPIKE_DECODER_SAT_EN to saturate the count and drive rate_sat.
module spike_decoder
    import spike_pkg::*;
#(
    parameter int WINDOW_W = WINDOW_W_DEF,
    parameter int COUNT_W  = COUNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                spike_in,
    input  logic                enable,
    input  logic [WINDOW_W-1:0] window_len,
    output logic [COUNT_W-1:0]  rate_out,
    output logic                rate_valid,
    input  logic                rate_ready,
    output logic                overrun,
    output logic                rate_sat
);
    state_t             state;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] next_count;
    logic               start;
    logic               run;
    logic               last;
    logic               restart;

    assign start = (state == IDLE) && enable;
    assign run   = (state == COUNT) && enable;

    spike_window_timer #(
        .WINDOW_W (WINDOW_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .run        (run),
        .window_len (window_len),
        .last       (last),
        .restart    (restart)
    );

`ifdef SPIKE_DECODER_SAT_EN
    logic ovf;
    logic sat_seen;

    assign ovf        = spike_in && (count == '1);
    assign next_count = ovf ? count : count + COUNT_W'(spike_in);

    // Saturation is sticky within a window and reported with that window's result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sat_seen <= 1'b0;
            rate_sat <= 1'b0;
        end else if (last) begin
            sat_seen <= 1'b0;
            rate_sat <= sat_seen || ovf;
        end else if (run) begin
            sat_seen <= sat_seen || ovf;
        end else begin
            sat_seen <= 1'b0;
        end
    end
`else
    assign next_count = count + COUNT_W'(spike_in);
    assign rate_sat   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= '0;
            rate_out   <= '0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
                    if (enable) state <= COUNT;
                end
                COUNT: begin
                    if (!enable) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (restart) begin
                        count <= '0;
                    end else begin
                        count <= next_count;
                    end
                end
                default: state <= IDLE;
            endcase

            // A load in the same cycle as a handshake replaces the consumed result cleanly.
            if (last) begin
                rate_out   <= next_count;
                rate_valid <= 1'b1;
                overrun    <= rate_valid && !rate_ready;
            end else if (rate_valid && rate_ready) begin
                rate_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/spike_decoder.md
SPIKE_DECODER -- requirements
Module: spike_decoder

Interface
REQ-001 SHALL have parameter WINDOW_W, default 8, meaning width of the window-length input.
REQ-002 SHALL have parameter COUNT_W, default 8, meaning width of the spike count and rate output.
REQ-003 SHALL have port clk, input, 1, clock; reset reset_n, synchronous, active-low; clock clk.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port spike_in, input, 1, spike train from a neuron; one spike per high cycle.
REQ-006 SHALL have port enable, input, 1, run decoding while high.
REQ-007 SHALL have port window_len, input, WINDOW_W, window length in cycles; 0 treated as 1.
REQ-008 SHALL have port rate_out, output, COUNT_W, spike count of the last completed window.
REQ-009 SHALL have port rate_valid, output, 1, rate_out holds an unconsumed result.
REQ-010 SHALL have port rate_ready, input, 1, consumer accepts rate_out when high with rate_valid.
REQ-011 SHALL have port overrun, output, 1, one-cycle pulse when an unconsumed result is overwritten.
REQ-012 SHALL have port rate_sat, output, 1, last result saturated; tied 0 when the saturation feature is compiled out.

Function
REQ-013 SHALL implement states IDLE, COUNT; IDLE->COUNT when enable=1, COUNT->IDLE when enable=0.
REQ-014 SHALL latch window_len on IDLE->COUNT and on every window restart; changes mid-window take effect at the next window.
REQ-015 SHALL, in COUNT, add spike_in to the running count every cycle, including the final window cycle.
REQ-016 SHALL, on the final cycle of a window, transfer the count (including that cycle's spike) to rate_out and assert rate_valid on the next cycle: latency 1 cycle after the window's last cycle.
REQ-017 SHALL restart the next window with count 0 immediately after the final cycle while enable=1; no dead cycles between windows.
REQ-018 SHALL complete a handshake when rate_valid=1 and rate_ready=1; rate_valid then clears unless a new result loads in the same cycle.
REQ-019 SHALL, when a new result loads while rate_valid=1 and rate_ready=0, overwrite rate_out, keep rate_valid=1, and pulse overrun for one cycle.
REQ-020 SHALL, when a new result loads in the same cycle as a completed handshake, keep rate_valid=1 and not pulse overrun.
REQ-021 SHALL, on enable=0 mid-window, discard the partial count and leave rate_out, rate_valid, and rate_sat unchanged.
REQ-022 SHALL hold rate_out stable while rate_valid=1 and no new result loads.

Reset
REQ-023 SHALL, on reset_n=0 at a clk edge, set state IDLE, count 0, window timer 0, rate_out 0, rate_valid 0, overrun 0, rate_sat 0.
REQ-024 SHALL abort any window in progress on reset, mid-operation included, with no result produced.

Configuration
REQ-025 SHALL use macro SPIKE_DECODER_SAT_EN: when defined, count saturates at 2^COUNT_W-1 and rate_sat reflects saturation of the loaded result.
REQ-026 SHALL, when SPIKE_DECODER_SAT_EN is undefined, wrap the count modulo 2^COUNT_W and tie rate_sat to 0.

Structure
REQ-027 SHALL place the state enum typedef and the default COUNT_W/WINDOW_W constants in shared package spike_pkg.
REQ-028 SHALL implement the window down-counter as sub-module spike_window_timer, with outputs for last-cycle and window-restart indications.

Verification
REQ-029 SHALL cover: window_len=4, spike_in=1,0,1,1 -> rate_out=3, rate_valid=1 one cycle after the 4th cycle.
REQ-030 SHALL cover: window_len=2, rate_ready=0, spikes 1,1 then 1,0 -> second result rate_out=1, overrun pulses once, rate_valid stays 1.
REQ-031 SHALL cover: window_len=3, enable dropped after 2 cycles with 2 spikes -> no new result; rate_out and rate_valid unchanged.
REQ-032 SHALL cover: SPIKE_DECODER_SAT_EN defined, COUNT_W=4, window_len=20, spike_in=1 constantly -> rate_out=15, rate_sat=1; macro undefined -> rate_out=4, rate_sat=0.
REQ-033 SHALL cover: reset_n=0 mid-window with 5 spikes counted -> all outputs 0 next cycle; after release with enable=1, the first window counts from 0.
REQ-034 SHALL cover: window_len=0 -> every cycle is a window, rate_out equals the previous cycle's spike_in.
